// File: rtl/decode_stage.sv
// Decode stage: field decode, 32x32 register file with writeback bypass,
// ID/EX pipeline register and load-use hazard detection.
module decode_stage #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            instr_in,
    input  logic                   wb_en,
    input  logic [REG_ADDR_W-1:0]  wb_addr,
    input  logic [31:0]            wb_data,
    output logic                   is_hazard,
    output logic                   id_valid,
    output logic [5:0]             id_opcode,
    output logic [5:0]             id_funct,
    output logic [REG_ADDR_W-1:0]  id_rs,
    output logic [REG_ADDR_W-1:0]  id_rt,
    output logic [REG_ADDR_W-1:0]  id_dest,
    output logic [31:0]            id_imm,
    output logic [31:0]            id_rs_data,
    output logic [31:0]            id_rt_data,
    output logic                   id_reg_write,
    output logic                   id_mem_read,
    output logic                   id_mem_write,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    typedef struct packed {
        logic                  valid;
        logic [5:0]            opcode;
        logic [5:0]            funct;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] dest;
        logic [31:0]           imm;
        logic [31:0]           rs_data;
        logic [31:0]           rt_data;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
    } id_t;

    id_t                    id_q, id_d, dec;
    logic [31:0]            rf_q [NUM_REGS];
    logic [31:0]            rf_d [NUM_REGS];
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
    logic [REG_ADDR_W-1:0]  dec_rd;
    logic                   uses_rs, uses_rt;

    always_comb begin
        dec           = '0;
        uses_rs       = 1'b0;
        uses_rt       = 1'b0;
        dec.valid     = (instr_in != 32'h0);
        dec.opcode    = instr_in[31:26];
        dec.funct     = instr_in[5:0];
        dec.rs        = instr_in[25:21];
        dec.rt        = instr_in[20:16];
        dec_rd        = instr_in[15:11];
        dec.imm       = {{16{instr_in[15]}}, instr_in[15:0]};
        if (dec.valid) begin
            uses_rs = 1'b1;
            case (dec.opcode)
                OP_RTYPE: begin
                    dec.reg_write = 1'b1;
                    dec.dest      = dec_rd;
                    uses_rt       = 1'b1;
                end
                OP_LW: begin
                    dec.mem_read  = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.dest      = dec.rt;
                end
                OP_SW: begin
                    dec.mem_write = 1'b1;
                    uses_rt       = 1'b1;
                end
                OP_ADDI: begin
                    dec.reg_write = 1'b1;
                    dec.dest      = dec.rt;
                end
                OP_BEQ:  uses_rt = 1'b1;
                default: ;
            endcase
            if (dec.dest == '0) dec.reg_write = 1'b0;
        end
        // Register 0 is hard-wired; a same-cycle writeback wins over the array.
        if (dec.rs == '0)                       dec.rs_data = 32'h0;
        else if (wb_en && (wb_addr == dec.rs))  dec.rs_data = wb_data;
        else                                    dec.rs_data = rf_q[dec.rs];
        if (dec.rt == '0)                       dec.rt_data = 32'h0;
        else if (wb_en && (wb_addr == dec.rt))  dec.rt_data = wb_data;
        else                                    dec.rt_data = rf_q[dec.rt];
    end

    assign is_hazard = id_q.valid & id_q.mem_read & (id_q.dest != '0) &
                       ((uses_rs & (dec.rs == id_q.dest)) |
                        (uses_rt & (dec.rt == id_q.dest)));

    always_comb begin
        id_d          = is_hazard ? '0 : dec;
        stall_count_d = stall_count_q;
        if (is_hazard && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
        rf_d = rf_q;
        if (wb_en && (wb_addr != '0)) rf_d[wb_addr] = wb_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            id_q          <= '0;
            stall_count_q <= '0;
            rf_q          <= '{default: '0};
        end else begin
            id_q          <= id_d;
            stall_count_q <= stall_count_d;
            rf_q          <= rf_d;
        end
    end

    assign id_valid     = id_q.valid;
    assign id_opcode    = id_q.opcode;
    assign id_funct     = id_q.funct;
    assign id_rs        = id_q.rs;
    assign id_rt        = id_q.rt;
    assign id_dest      = id_q.dest;
    assign id_imm       = id_q.imm;
    assign id_rs_data   = id_q.rs_data;
    assign id_rt_data   = id_q.rt_data;
    assign id_reg_write = id_q.reg_write;
    assign id_mem_read  = id_q.mem_read;
    assign id_mem_write = id_q.mem_write;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a reference model pushes the expected
// ID/EX contents per cycle, popped and compared after each rising edge.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        is_hazard, id_valid, id_reg_write, id_mem_read, id_mem_write;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic [31:0] id_imm, id_rs_data, id_rt_data;
    logic [15:0] stall_count;

    decode_stage dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .is_hazard(is_hazard),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest), .id_imm(id_imm),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [15:0] stall;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m_id;
    logic [31:0] m_rf [32];
    logic        m_init = 1'b0;
    logic        last_haz;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (we && wa == a) return wd;
        return m_rf[a];
    endfunction

    task automatic model_decode(input logic [31:0] ins, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, output exp_t e, output logic ur, output logic ut);
        e = '0; ur = 1'b0; ut = 1'b0;
        e.opcode  = ins[31:26];
        e.funct   = ins[5:0];
        e.rs      = ins[25:21];
        e.rt      = ins[20:16];
        e.imm     = {{16{ins[15]}}, ins[15:0]};
        e.rs_data = m_read(ins[25:21], we, wa, wd);
        e.rt_data = m_read(ins[20:16], we, wa, wd);
        if (ins != 32'h0) begin
            e.valid = 1'b1;
            ur = 1'b1;
            if (ins[31:26] == 6'h00) begin e.dest = ins[15:11]; e.reg_write = 1'b1; ut = 1'b1; end
            if (ins[31:26] == 6'h23) begin e.dest = ins[20:16]; e.reg_write = 1'b1; e.mem_read = 1'b1; end
            if (ins[31:26] == 6'h2B) begin e.mem_write = 1'b1; ut = 1'b1; end
            if (ins[31:26] == 6'h08) begin e.dest = ins[20:16]; e.reg_write = 1'b1; end
            if (ins[31:26] == 6'h04) ut = 1'b1;
            if (e.dest == 5'd0) e.reg_write = 1'b0;
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic r, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd);
        exp_t dec, e;
        logic ur, ut, h;
        @(negedge clk);
        instr_in = ins; rst = r; wb_en = we; wb_addr = wa; wb_data = wd;
        model_decode(ins, we, wa, wd, dec, ur, ut);
        h = m_id.valid && m_id.mem_read && (m_id.dest != 5'd0) &&
            ((ur && ins[25:21] == m_id.dest) || (ut && ins[20:16] == m_id.dest));
        #1;
        last_haz = is_hazard;
        if (m_init) chk("is_hazard", {31'b0, is_hazard}, {31'b0, h});
        if (!r) begin
            m_id = '0;
            for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
            m_init = 1'b1;
        end else begin
            dec.stall = m_id.stall;
            if (h && m_id.stall != 16'hFFFF) dec.stall = m_id.stall + 16'd1;
            if (h) begin
                e = '0;
                e.stall = dec.stall;
                dec = e;
            end
            m_id = dec;
            if (we && wa != 5'd0) m_rf[wa] = wd;
        end
        exp_q.push_back(m_id);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("id_valid",     {31'b0, id_valid},     {31'b0, e.valid});
            chk("id_opcode",    {26'b0, id_opcode},    {26'b0, e.opcode});
            chk("id_funct",     {26'b0, id_funct},     {26'b0, e.funct});
            chk("id_rs",        {27'b0, id_rs},        {27'b0, e.rs});
            chk("id_rt",        {27'b0, id_rt},        {27'b0, e.rt});
            chk("id_dest",      {27'b0, id_dest},      {27'b0, e.dest});
            chk("id_imm",       id_imm,                e.imm);
            chk("id_rs_data",   id_rs_data,            e.rs_data);
            chk("id_rt_data",   id_rt_data,            e.rt_data);
            chk("id_reg_write", {31'b0, id_reg_write}, {31'b0, e.reg_write});
            chk("id_mem_read",  {31'b0, id_mem_read},  {31'b0, e.mem_read});
            chk("id_mem_write", {31'b0, id_mem_write}, {31'b0, e.mem_write});
            chk("stall_count",  {16'b0, stall_count},  {16'b0, e.stall});
        end
    endtask

    localparam logic [31:0] LW_R2  = 32'h8C220004;
    localparam logic [31:0] ADD_R3 = 32'h00441820;
    localparam logic [31:0] ADDI_1 = 32'h20A20001;
    localparam logic [31:0] LW_R0  = 32'h8C200000;
    localparam logic [31:0] ADD_00 = 32'h00001820;
    localparam logic [31:0] ADDI_M = 32'h20A2FFFF;

    initial begin
        logic [31:0] ins;
        logic [5:0]  op;
        m_id = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        rst = 1'b0; instr_in = 32'h0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;

        // reset held two cycles with a load on the input
        step(LW_R2, 1'b0, 1'b0, 5'd0, 32'h0);
        step(LW_R2, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("rst_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_stall", {16'b0, stall_count}, 32'd0);
        chk("rst_haz", {31'b0, is_hazard}, 32'd0);
        step(LW_R2, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("rel_mem_read", {31'b0, id_mem_read}, 32'd1);
        chk("rel_dest", {27'b0, id_dest}, 32'd2);
        chk("rel_imm", id_imm, 32'd4);

        // load-use: one stall then the add issues
        step(ADD_R3, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("lu_haz1", {31'b0, last_haz}, 32'd1);
        chk("lu_bubble", {31'b0, id_valid}, 32'd0);
        step(ADD_R3, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("lu_haz2", {31'b0, last_haz}, 32'd0);
        chk("lu_dest", {27'b0, id_dest}, 32'd3);
        chk("lu_stall", {16'b0, stall_count}, 32'd1);

        // no false hazards
        step(LW_R2, 1'b1, 1'b0, 5'd0, 32'h0);
        step(ADDI_1, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("addi_rt_nohaz", {31'b0, last_haz}, 32'd0);
        step(LW_R0, 1'b1, 1'b0, 5'd0, 32'h0);
        step(ADD_00, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("lw_r0_nohaz", {31'b0, last_haz}, 32'd0);

        // bypass, persistence and register 0
        step(ADDI_M, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
        chk("bypass_rs", id_rs_data, 32'hDEADBEEF);
        chk("bypass_imm", id_imm, 32'hFFFFFFFF);
        step(ADDI_M, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("rf_r5", id_rs_data, 32'hDEADBEEF);
        step(ADD_00, 1'b1, 1'b1, 5'd0, 32'h1234);
        chk("r0_bypass", id_rs_data, 32'h0);
        step(ADD_00, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("r0_read", id_rs_data, 32'h0);

        // reset on the hazard cycle
        step(LW_R2, 1'b1, 1'b0, 5'd0, 32'h0);
        step(ADD_R3, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("mid_haz", {31'b0, last_haz}, 32'd1);
        chk("mid_valid", {31'b0, id_valid}, 32'd0);
        chk("mid_stall", {16'b0, stall_count}, 32'd0);
        step(ADDI_M, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("mid_valid2", {31'b0, id_valid}, 32'd1);
        chk("mid_rf_clr", id_rs_data, 32'h0);

        // saturation of the stall counter
        force dut.stall_count_q = 16'hFFFE;
        #1;
        release dut.stall_count_q;
        m_id.stall = 16'hFFFE;
        for (int k = 0; k < 3; k++) begin
            step(LW_R2, 1'b1, 1'b0, 5'd0, 32'h0);
            step(ADD_R3, 1'b1, 1'b0, 5'd0, 32'h0);
            chk("sat_haz", {31'b0, last_haz}, 32'd1);
            step(ADD_R3, 1'b1, 1'b0, 5'd0, 32'h0);
        end
        chk("sat_value", {16'b0, stall_count}, 32'h0000FFFF);

        // random traffic over a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 6))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h08;
                4: op = 6'h04;
                5: op = 6'h0F;
                default: op = 6'h23;
            endcase
            ins = {op, 2'b0, 3'($urandom_range(0, 7)), 2'b0, 3'($urandom_range(0, 7)),
                   16'($urandom)};
            if ($urandom_range(0, 15) == 0) ins = 32'h0;
            step(ins, ($urandom_range(0, 59) != 0), 1'($urandom),
                 5'($urandom_range(0, 7)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
